// File: rtl/fp_fma_sched_pkg.sv
// Shared types for the fp_fma issue scheduler: the fp_fma port structs it routes
// and the tag that follows each operation through the pipeline.
package fp_fma_sched_pkg;

    localparam int FP_TAG_IDW = 4;

    typedef struct packed {
        logic fmadd;
        logic fmsub;
        logic fnmsub;
        logic fnmadd;
        logic fadd;
        logic fsub;
        logic fmul;
    } fp_operation_type;

    typedef struct packed {
        logic [63:0]      data1;
        logic [63:0]      data2;
        logic [63:0]      data3;
        logic [9:0]       class1;
        logic [9:0]       class2;
        logic [9:0]       class3;
        fp_operation_type op;
        logic [1:0]       fmt;
        logic [2:0]       rm;
    } fp_fma_in_type;

    typedef struct packed {
        logic        sig;
        logic [10:0] expo;
        logic [51:0] mant;
        logic [1:0]  fmt;
        logic [2:0]  rm;
    } fp_rnd_in_type;

    typedef struct packed {
        fp_rnd_in_type fp_rnd;
        logic          ready;
    } fp_fma_out_type;

    // Owner of one in-flight operation; id is wide enough for up to 16 requesters.
    typedef struct packed {
        logic                  valid;
        logic [FP_TAG_IDW-1:0] id;
    } fp_fma_tag_type;

    localparam fp_fma_tag_type init_fp_fma_tag = '0;

endpackage

// File: rtl/fp_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr,
// ptr advancing past the winner on every grant.
module fp_rr_arb #(
    parameter int NREQ = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic                    en,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] gnt_id
);
    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] ptr_reg;
    logic [IW-1:0] ptr_next;
    logic [IW-1:0] scan_idx;
    logic          found;

    always_comb begin
        gnt      = '0;
        gnt_id   = '0;
        found    = 1'b0;
        scan_idx = '0;
        ptr_next = ptr_reg;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = IW'((int'(ptr_reg) + k) % NREQ);
            if (en && !reset && !found && req[scan_idx]) begin
                found         = 1'b1;
                gnt[scan_idx] = 1'b1;
                gnt_id        = scan_idx;
            end
        end
        if (found) begin
            ptr_next = (gnt_id == IW'(NREQ - 1)) ? '0 : gnt_id + IW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/fp_fma_sched.sv
// Shares one fp_fma pipeline between NREQ requesters and routes each result
// back to its owner through a LAT-deep tag pipe.
module fp_fma_sched
    import fp_fma_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int LAT  = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  fp_fma_in_type            req_data [NREQ],
    output logic [NREQ-1:0]          req_ready,
    input  logic                     flush,
    output fp_fma_in_type            fma_i,
    input  fp_fma_out_type           fma_o,
    output logic                     resp_valid,
    output logic [$clog2(NREQ)-1:0]  resp_id,
    output fp_rnd_in_type            resp_data,
    output logic [$clog2(LAT+1)-1:0] inflight,
    output logic                     err
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(LAT + 1);

    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_id;
    logic            gnt_any;
    logic            arb_en;

    assign arb_en = ~flush;

    fp_rr_arb #(.NREQ(NREQ)) u_arb (
        .clock  (clock),
        .reset  (reset),
        .req    (req_valid),
        .en     (arb_en),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign gnt_any   = |gnt;
    assign req_ready = gnt;

    // Idle cycles still present requester 0's operands, but with no op bit set.
    always_comb begin
        fma_i    = req_data[0];
        fma_i.op = '0;
        if (gnt_any) begin
            fma_i = req_data[gnt_id];
        end
    end

    fp_fma_tag_type tag_reg  [LAT];
    fp_fma_tag_type tag_next [LAT];

    assign tag_next[0] = '{valid: gnt_any, id: FP_TAG_IDW'(gnt_id)};

    generate
        for (genvar gi = 1; gi < LAT; gi++) begin : g_tag_shift
            assign tag_next[gi] = tag_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clock) begin
        for (int k = 0; k < LAT; k++) begin
            tag_reg[k] <= (reset || flush) ? init_fp_fma_tag : tag_next[k];
        end
    end

    logic                  retire;
    logic [FP_TAG_IDW-1:0] tail_id;

    assign retire     = tag_reg[LAT-1].valid;
    assign tail_id    = tag_reg[LAT-1].id;
    assign resp_valid = retire & fma_o.ready;
    assign resp_id    = tail_id[IW-1:0];
    assign resp_data  = fma_o.fp_rnd;

    generate
        if (IW < FP_TAG_IDW) begin : g_tag_hi
            logic unused_tag_hi;
            assign unused_tag_hi = |tail_id[FP_TAG_IDW-1:IW];
        end
    endgenerate

    logic [CW-1:0] inflight_reg, inflight_next;
    logic [CW-1:0] sup_reg, sup_next;
    logic          err_reg, err_next;

    // Flushed operations still leave fp_fma untagged, so the ready/tag
    // cross-check is masked for LAT cycles after a flush.
    always_comb begin
        inflight_next = inflight_reg;
        sup_next      = sup_reg;
        err_next      = err_reg | ((sup_reg == '0) && (retire != fma_o.ready));
        if (flush) begin
            inflight_next = '0;
            sup_next      = CW'(LAT);
        end else begin
            if (gnt_any && !retire && inflight_reg != CW'(LAT)) begin
                inflight_next = inflight_reg + CW'(1);
            end else if (retire && !gnt_any && inflight_reg != '0) begin
                inflight_next = inflight_reg - CW'(1);
            end
            if (sup_reg != '0) begin
                sup_next = sup_reg - CW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            inflight_reg <= '0;
            sup_reg      <= '0;
            err_reg      <= 1'b0;
        end else begin
            inflight_reg <= inflight_next;
            sup_reg      <= sup_next;
            err_reg      <= err_next;
        end
    end

    assign inflight = inflight_reg;
    assign err      = err_reg;

endmodule

// File: doc/fp_fma_sched.md
# fp_fma_sched

Issue scheduler that shares one `fp_fma` pipeline between `NREQ` requesters. Each cycle it round-robin-grants at most one valid request and drives that operation into `fp_fma`. It tracks the requester id of every in-flight operation in a tag shift register and returns each `fp_rnd` result to its owner. It sits between the FPU front-end ports and the `fp_fma` instance and owns that instance's `fp_fma_i` input.

## Interface
- `NREQ`, default 4: number of requesters; must be at least 2.
- `LAT`, default 4: `fp_fma` issue-to-result latency in cycles; must match the pipeline depth.
- `clock` in, 1 bit: single clock, rising edge.
- `reset` in, 1 bit: synchronous reset, active-high.
- `req_valid` in, `NREQ` bits: request pending, one bit per requester.
- `req_data` in, `NREQ` x `fp_fma_in_type`: operands, classes, fmt, rm and op per requester.
- `req_ready` out, `NREQ` bits: one-hot grant; the request is consumed in any cycle where `req_valid[i] & req_ready[i]`.
- `flush` in, 1 bit: discard every in-flight operation.
- `fma_i` out, `fp_fma_in_type`: drives the `fp_fma` input.
- `fma_o` in, `fp_fma_out_type`: result from `fp_fma`.
- `resp_valid` out, 1 bit: result valid this cycle.
- `resp_id` out, `$clog2(NREQ)` bits: owner of the result.
- `resp_data` out, `fp_rnd_in_type`: equals `fma_o.fp_rnd`.
- `inflight` out, `$clog2(LAT+1)` bits: number of live tags.
- `err` out, 1 bit: sticky tag/ready mismatch flag.

## Operation
- Round-robin arbitration with pointer `ptr`:
  - The grant goes to the first index `i`, searching from `ptr` upward and wrapping, with `req_valid[i]=1`.
  - On a grant, `ptr` becomes `(i+1) mod NREQ`. With no grant, `ptr` is held.
- `req_ready` is combinational from `req_valid`, `ptr`, `flush` and `reset`. It is all-zero while `reset` or `flush` is high.
- `fma_i` selection:
  - With a grant, `fma_i` is `req_data[grant]`.
  - With no grant, `fma_i` is `req_data[0]` with every op bit forced to 0, so `fp_fma` sees no operation.
- Tag pipe has `LAT` entries, each `{valid, id}`. Entry 0 loads `{grant_any, grant_id}`; entry k loads entry k-1.
- `resp_valid = tag[LAT-1].valid & fma_o.ready`. `resp_id = tag[LAT-1].id`.
- `err` is set when `tag[LAT-1].valid != fma_o.ready` in any non-reset cycle. It is cleared only by `reset`.
- `flush`:
  - All tag valid bits clear at the next edge and no grant is made in the flush cycle.
  - Results from flushed ops still emerge from `fp_fma` with `ready=1` and untagged. `err` is suppressed for the next `LAT` cycles after a `flush`, using a down-counter that loads `LAT`.
- `inflight` counter update:
  - It gains 1 on a grant and loses 1 when `tag[LAT-1].valid` is set.
  - It does not change when both happen in the same cycle.
  - It becomes 0 on `flush`.
  - It never exceeds `LAT`.
- Requesters must accept results unconditionally. There is no response backpressure.

## Timing
- Reset values: `ptr=0`, all tags invalid, `inflight=0`, `err=0`, flush suppress counter 0, `req_ready=0`, `fma_i` op bits 0, `resp_valid=0`.
- A grant in cycle t gives `resp_valid` in cycle t+`LAT`. Throughput is one op per cycle.
- Simultaneous grant and retirement leave `inflight` unchanged.
- `reset` asserted mid-operation:
  - Tags clear at the same edge.
  - `fp_fma` is reset alongside and is driven by the same `reset` inverted to its active-low input.
  - No `resp_valid` appears for pre-reset ops.
- A `flush` and a `reset` in the same cycle behave as `reset`.
- A requester holding `req_valid` while others compete is granted within `NREQ` cycles.

## Structure
- `fp_wire` package additions:
  - `fp_fma_tag_type`, holding `valid` and `id`.
  - `init_fp_fma_tag` constant, all zero.
- Sub-module `fp_rr_arb`:
  - Parameter `NREQ`.
  - Inputs `clock`, `reset`, `req`, `en`.
  - Outputs `gnt` (one-hot) and `gnt_id`.
  - Contains `ptr`.
- The scheduler top holds the tag pipe, the `inflight` counter, the flush suppress counter and the `err` logic. It is instantiated alongside `fp_fma` and the `lzc` block.

## Test plan
- Single requester: with `req_valid=4'b0001` for one cycle doing fmadd 1.0*2.0+3.0 in double, `req_ready[0]=1` in that cycle. `resp_valid=1`, `resp_id=0` and `resp_data` (expo/mant) representing 5.0 arrive exactly 4 cycles later.
- All four requesters valid continuously for 8 cycles: grants go 0,1,2,3,0,1,2,3. `resp_id` follows the same sequence 4 cycles later. `inflight` holds at 4.
- Requesters 1 and 3 valid, `ptr=2`: grant goes to 3, then to 1.
- `flush` one cycle after 3 back-to-back grants: no `resp_valid` for those ops, `inflight=0` on the next cycle, `err` stays 0.
- `reset` held high 1 cycle with 2 ops in flight: all outputs return to their reset values, no responses follow, and the next grant is to requester 0.
- Force `fma_o.ready=1` with no live tag outside the suppress window: `err=1` and it stays 1 until `reset`.
